// File: rtl/buffer_receiver_if.sv
// Serial-to-byte receive buffer bus: bit stream in, byte pops out, fill status.
interface buffer_receiver_if #(parameter int ADDR_W = 7);
   logic                input_bit;
   logic                bit_valid;
   logic                read_req;
   logic [7:0]          read_data;
   logic                read_valid;
   logic [ADDR_W+3:0]   bits_used;
   logic [ADDR_W:0]     bytes_ready;
   logic                full;
   logic                empty;
   logic                overflow;

   modport master (
      output input_bit, bit_valid, read_req,
      input  read_data, read_valid, bits_used, bytes_ready, full, empty, overflow
   );

   modport slave (
      input  input_bit, bit_valid, read_req,
      output read_data, read_valid, bits_used, bytes_ready, full, empty, overflow
   );
endinterface

// File: rtl/buffer_receiver.sv
// Assembles an LSB-first serial bit stream into bytes held in a 2^ADDR_W byte FIFO;
// bytes are popped one per request with one cycle of latency.
module buffer_receiver #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   buffer_receiver_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W+3:0] CAP_BITS = (ADDR_W+4)'(8 << ADDR_W);

   logic [7:0]        mem [DEPTH];
   logic [7:0]        asm_byte;
   logic [2:0]        bit_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   bytes_ready;
   logic [ADDR_W:0]   bytes_next;
   logic [7:0]        read_data_p1;
   logic              vld_p1;
   logic              overflow;
   logic              full;
   logic              accept;
   logic              byte_done;
   logic              pop;

   // bits_used is exactly 8*bytes_ready + bit_cnt, so it is a plain concatenation
   assign bus.bits_used   = {bytes_ready, bit_cnt};
   assign full            = (bus.bits_used == CAP_BITS);
   assign bus.full        = full;
   assign bus.empty       = (bus.bits_used == '0);
   assign bus.bytes_ready = bytes_ready;
   assign bus.read_data   = read_data_p1;
   assign bus.read_valid  = vld_p1;
   assign bus.overflow    = overflow;

   // A pop cannot make room for a bit in the same cycle: accept looks at full only
   assign accept    = rst & bus.bit_valid & ~full;
   assign byte_done = accept & (bit_cnt == 3'd7);
   assign pop       = rst & bus.read_req & (bytes_ready != '0);

   always_comb begin
      bytes_next = bytes_ready;
      case ({byte_done, pop})
         2'b10:   bytes_next = bytes_ready + (ADDR_W+1)'(1);
         2'b01:   bytes_next = bytes_ready - (ADDR_W+1)'(1);
         default: bytes_next = bytes_ready;
      endcase
   end

   // Data storage: never reset; stale contents are unreachable once the pointers clear
   always_ff @(posedge clk) begin
      if (accept) asm_byte[bit_cnt] <= bus.input_bit;
      if (byte_done) mem[wr_ptr] <= {bus.input_bit, asm_byte[6:0]};
   end

   // Stage p1: popped byte and its qualifier
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bytes_ready  <= '0;
         vld_p1       <= 1'b0;
         read_data_p1 <= 8'h00;
         overflow     <= 1'b0;
      end else begin
         bytes_ready <= bytes_next;
         vld_p1      <= pop;
         if (accept)    bit_cnt <= bit_cnt + 3'd1;
         if (byte_done) wr_ptr  <= wr_ptr + ADDR_W'(1);
         if (pop) begin
            rd_ptr       <= rd_ptr + ADDR_W'(1);
            read_data_p1 <= mem[rd_ptr];
         end
         if (bus.bit_valid && full) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_buffer_receiver.sv
// Randomized bench for buffer_receiver against a queue-based model of the bit/byte FIFO.
module tb_buffer_receiver;
   localparam int ADDR_W = 7;
   localparam int CAP    = 8 << ADDR_W;
   localparam int BU_W   = ADDR_W + 4;
   localparam int BR_W   = ADDR_W + 1;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   buffer_receiver_if #(.ADDR_W(ADDR_W)) bus ();

   buffer_receiver #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of complete bytes plus the partial byte being assembled
   logic [7:0] byte_q [$];
   logic [7:0] part_val;
   int         part_cnt;
   logic       m_ovf;
   logic       m_rv;
   logic [7:0] m_rd;

   function automatic int m_bits();
      return byte_q.size() * 8 + part_cnt;
   endfunction

   function automatic void model_reset();
      byte_q.delete();
      part_val = 8'h00;
      part_cnt = 0;
      m_ovf    = 1'b0;
      m_rv     = 1'b0;
      m_rd     = 8'h00;
   endfunction

   function automatic void model_step(input logic bv, input logic ib, input logic rr);
      int bits_pre;
      bits_pre = m_bits();
      m_rv = 1'b0;
      if (rr && byte_q.size() > 0) begin
         m_rd = byte_q.pop_front();
         m_rv = 1'b1;
      end
      if (bv) begin
         if (bits_pre == CAP) m_ovf = 1'b1;
         else begin
            part_val[part_cnt] = ib;
            part_cnt++;
            if (part_cnt == 8) begin
               byte_q.push_back(part_val);
               part_cnt = 0;
               part_val = 8'h00;
            end
         end
      end
   endfunction

   task automatic cycle(input logic bv, input logic ib, input logic rr);
      bus.bit_valid = bv;
      bus.input_bit = ib;
      bus.read_req  = rr;
      @(posedge clk);
      #1;
      model_step(bv, ib, rr);
      bus.bit_valid = 1'b0;
      bus.input_bit = 1'b0;
      bus.read_req  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.bit_valid = 1'b0;
      bus.input_bit = 1'b0;
      bus.read_req  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (bus.bits_used !== '0 || bus.bytes_ready !== '0 || bus.read_valid !== 1'b0 ||
          bus.read_data !== 8'h00 || bus.overflow !== 1'b0) begin
         $display("FAIL reset_counts: bits_used=%0d bytes_ready=%0d read_valid=%b read_data=%h overflow=%b, required all zero",
                  bus.bits_used, bus.bytes_ready, bus.read_valid, bus.read_data, bus.overflow);
         miscompares++;
      end
      vectors++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         $display("FAIL reset_flags: empty=%b full=%b, required empty=1 full=0", bus.empty, bus.full);
         miscompares++;
      end
   endtask

   task automatic test_basic_byte();
      logic [7:0] pattern;
      pattern = 8'h85;
      for (int i = 0; i < 8; i++) cycle(1'b1, pattern[i], 1'b0);
      vectors++;
      if (bus.bytes_ready !== BR_W'(1) || bus.bits_used !== BU_W'(8)) begin
         $display("FAIL basic_fill: bytes_ready=%0d bits_used=%0d, required 1 and 8", bus.bytes_ready, bus.bits_used);
         miscompares++;
      end
      cycle(1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.read_data !== 8'h85 || bus.read_valid !== 1'b1 || bus.bits_used !== '0 || bus.empty !== 1'b1) begin
         $display("FAIL basic_pop: read_data=%h read_valid=%b bits_used=%0d empty=%b, required 85 1 0 1",
                  bus.read_data, bus.read_valid, bus.bits_used, bus.empty);
         miscompares++;
      end
      cycle(1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.read_valid !== 1'b0 || bus.read_data !== 8'h85) begin
         $display("FAIL basic_pulse: read_valid=%b read_data=%h, required 0 and 85", bus.read_valid, bus.read_data);
         miscompares++;
      end
   endtask

   task automatic test_partial();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.read_valid !== 1'b0 || bus.bits_used !== BU_W'(3) || bus.read_data !== m_rd) begin
         $display("FAIL partial_ignored: read_valid=%b bits_used=%0d read_data=%h, required 0 3 %h",
                  bus.read_valid, bus.bits_used, bus.read_data, m_rd);
         miscompares++;
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.read_valid !== 1'b1 || bus.read_data !== m_rd || bus.bits_used !== '0) begin
         $display("FAIL partial_complete: read_valid=%b read_data=%h bits_used=%0d, required 1 %h 0",
                  bus.read_valid, bus.read_data, bus.bits_used, m_rd);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         vectors++;
         if (bus.read_valid !== m_rv || bus.read_data !== m_rd || bus.bytes_ready !== BR_W'(byte_q.size())) begin
            $display("FAIL back_to_back[%0d]: read_valid=%b read_data=%h bytes_ready=%0d, required %b %h %0d",
                     i, bus.read_valid, bus.read_data, bus.bytes_ready, m_rv, m_rd, byte_q.size());
            miscompares++;
         end
      end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < CAP; i++) cycle(1'b1, 1'($urandom_range(1)), 1'b0);
      vectors++;
      if (bus.full !== 1'b1 || bus.bits_used !== BU_W'(CAP) || bus.bytes_ready !== BR_W'(CAP / 8) ||
          bus.overflow !== 1'b0 || bus.empty !== 1'b0) begin
         $display("FAIL full_reached: full=%b bits_used=%0d bytes_ready=%0d overflow=%b empty=%b, required 1 %0d %0d 0 0",
                  bus.full, bus.bits_used, bus.bytes_ready, bus.overflow, bus.empty, CAP, CAP / 8);
         miscompares++;
      end
      cycle(1'b1, 1'b1, 1'b0);
      vectors++;
      if (bus.overflow !== 1'b1 || bus.bits_used !== BU_W'(CAP)) begin
         $display("FAIL full_drop: overflow=%b bits_used=%0d, required 1 %0d", bus.overflow, bus.bits_used, CAP);
         miscompares++;
      end
      cycle(1'b1, 1'b1, 1'b1);
      vectors++;
      if (bus.bits_used !== BU_W'(CAP - 8) || bus.read_valid !== 1'b1 || bus.read_data !== m_rd ||
          bus.overflow !== 1'b1 || bus.full !== 1'b0) begin
         $display("FAIL full_pop_drop: bits_used=%0d read_valid=%b read_data=%h overflow=%b full=%b, required %0d 1 %h 1 0",
                  bus.bits_used, bus.read_valid, bus.read_data, bus.overflow, bus.full, CAP - 8, m_rd);
         miscompares++;
      end
      cycle(1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus.bits_used !== BU_W'(CAP - 7) || bus.overflow !== 1'b1) begin
         $display("FAIL after_full_accept: bits_used=%0d overflow=%b, required %0d 1", bus.bits_used, bus.overflow, CAP - 7);
         miscompares++;
      end
   endtask

   task automatic test_random_stream();
      int accepted;
      int guard;
      int dut_pops;
      logic bv, ib, rr;
      accepted = 0;
      guard    = 0;
      dut_pops = 0;
      do_reset();
      while ((accepted < 2 * CAP || byte_q.size() > 0) && guard < 20000) begin
         if (accepted < 2 * CAP) begin
            bv = ($urandom_range(3) != 0);
            rr = ($urandom_range(3) == 0);
         end else begin
            bv = 1'b0;
            rr = 1'b1;
         end
         ib = 1'($urandom_range(1));
         if (bv && m_bits() < CAP) accepted++;
         cycle(bv, ib, rr);
         if (bus.read_valid === 1'b1) dut_pops++;
         vectors++;
         if (bus.bits_used !== BU_W'(m_bits()) || bus.bytes_ready !== BR_W'(byte_q.size()) ||
             bus.read_valid !== m_rv || bus.read_data !== m_rd || bus.empty !== (m_bits() == 0) ||
             bus.full !== (m_bits() == CAP) || bus.overflow !== m_ovf) begin
            $display("FAIL stream[%0d]: bits_used=%0d bytes_ready=%0d read_valid=%b read_data=%h empty=%b full=%b overflow=%b, required %0d %0d %b %h %b %b %b",
                     guard, bus.bits_used, bus.bytes_ready, bus.read_valid, bus.read_data, bus.empty, bus.full,
                     bus.overflow, m_bits(), byte_q.size(), m_rv, m_rd, m_bits() == 0, m_bits() == CAP, m_ovf);
            miscompares++;
         end
         guard++;
      end
      vectors++;
      if (guard >= 20000 || dut_pops != 2 * CAP / 8) begin
         $display("FAIL stream_total: pops=%0d cycles=%0d, required %0d pops within 20000 cycles", dut_pops, guard, 2 * CAP / 8);
         miscompares++;
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] first;
      logic [7:0] after;
      first = 8'hA7;
      after = 8'h3C;
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, first[i], 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
      #3;
      rst = 1'b0;
      bus.bit_valid = 1'b1;
      bus.input_bit = 1'b1;
      bus.read_req  = 1'b1;
      #1;
      vectors++;
      if (bus.bits_used !== '0 || bus.bytes_ready !== '0 || bus.read_data !== 8'h00 || bus.read_valid !== 1'b0 ||
          bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
         $display("FAIL async_reset_now: bits_used=%0d bytes_ready=%0d read_data=%h read_valid=%b empty=%b full=%b overflow=%b, required 0 0 00 0 1 0 0",
                  bus.bits_used, bus.bytes_ready, bus.read_data, bus.read_valid, bus.empty, bus.full, bus.overflow);
         miscompares++;
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      vectors++;
      if (bus.bits_used !== '0 || bus.read_valid !== 1'b0) begin
         $display("FAIL async_reset_hold: bits_used=%0d read_valid=%b, required 0 0", bus.bits_used, bus.read_valid);
         miscompares++;
      end
      rst = 1'b1;
      model_reset();
      bus.bit_valid = 1'b0;
      bus.input_bit = 1'b0;
      bus.read_req  = 1'b0;
      for (int i = 0; i < 8; i++) cycle(1'b1, after[i], 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.read_valid !== 1'b1 || bus.read_data !== 8'h3C || bus.bits_used !== '0) begin
         $display("FAIL async_restart: read_valid=%b read_data=%h bits_used=%0d, required 1 3c 0",
                  bus.read_valid, bus.read_data, bus.bits_used);
         miscompares++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0;
      bus.bit_valid = 1'b0;
      bus.input_bit = 1'b0;
      bus.read_req  = 1'b0;
      model_reset();
      test_reset();
      test_basic_byte();
      test_partial();
      test_back_to_back();
      test_full_overflow();
      test_random_stream();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/buffer_receiver.md
BUFFER_RECEIVER -- requirements
Module: buffer_receiver

Interface
REQ-001 Parameter ADDR_W, default 7, byte-address width; storage SHALL be 2^ADDR_W bytes (1024 bits at default).
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 input_bit  input  1  serial data bit.
REQ-005 bit_valid  input  1  input_bit is sampled this cycle.
REQ-006 read_req  input  1  request to pop one stored byte.
REQ-007 read_data  output  8  popped byte, registered.
REQ-008 read_valid  output  1  one-cycle pulse qualifying read_data.
REQ-009 bits_used  output  ADDR_W+4  count of bits held, including the partial byte (0..1024 at default).
REQ-010 bytes_ready  output  ADDR_W+1  count of complete bytes held.
REQ-011 full  output  1  high when bits_used equals 8*2^ADDR_W.
REQ-012 empty  output  1  high when bits_used equals 0.
REQ-013 overflow  output  1  sticky flag: a bit was dropped.

Function
REQ-014 Bit ordering SHALL be LSB-first: stream bit k SHALL land in byte k/8 at position k%8, the inverse of the team's serial transmitter.
REQ-015 Accept: bit_valid=1 and full=0 -> input_bit SHALL be written into assembly register position bit_cnt[2:0], and bit_cnt SHALL increment modulo 8.
REQ-016 On the accept that makes bit_cnt wrap 7->0, the completed byte SHALL be written to memory at wr_ptr the same edge, wr_ptr SHALL increment modulo 2^ADDR_W, and bytes_ready SHALL increment.
REQ-017 Pop: read_req=1 and bytes_ready>0 -> memory[rd_ptr] SHALL appear on read_data with read_valid=1 on the next cycle (latency 1), and rd_ptr SHALL increment modulo 2^ADDR_W.
REQ-018 read_req with bytes_ready=0 SHALL be ignored; read_valid stays 0, read_data holds its last value, and the partial byte is never poppable.
REQ-019 bits_used SHALL equal 8*bytes_ready + bit_cnt at every cycle boundary; +1 per accept, -8 per pop.
REQ-020 Simultaneous accept and pop SHALL both take effect (net bits_used -7); a byte completing this cycle SHALL NOT be poppable until the next cycle.
REQ-021 bit_valid while full=1 SHALL drop the bit, leave all counters unchanged, and set overflow, which remains 1 until reset.
REQ-022 When full=1, the same-cycle pop SHALL NOT free space for a bit presented that cycle; that bit SHALL be dropped per REQ-021.
REQ-023 Pointer wrap SHALL be seamless; FIFO order SHALL be preserved across any number of wraps.
REQ-024 read_valid SHALL be a single-cycle pulse per accepted pop; back-to-back read_req SHALL yield back-to-back pulses while bytes_ready>0.

Reset
REQ-025 rst=0 SHALL immediately clear bit_cnt, wr_ptr, rd_ptr, bytes_ready, bits_used, read_valid, overflow, and read_data (8'h00), and SHALL set empty=1 and full=0; memory contents need not be cleared.
REQ-026 Reset mid-byte or mid-pop SHALL discard all held data; the first accept after release is stream bit 0.
REQ-027 Inputs SHALL be ignored while rst=0.

Verification
REQ-028 Reset, then 8 accepts of bits 1,0,1,0,0,0,0,1 -> bytes_ready=1, bits_used=8; read_req -> next cycle read_data=8'h85, read_valid=1, bits_used=0, empty=1.
REQ-029 1024 accepts -> full=1, bits_used=1024; 1025th bit -> dropped, overflow=1, bits_used stays 1024.
REQ-030 Full, then bit_valid and read_req in the same cycle -> bit dropped, overflow=1, bits_used=1016, byte 0 returned.
REQ-031 Fill 3 bits, read_req -> read_valid stays 0 and bits_used stays 3; 5 more bits, then read_req -> byte returned.
REQ-032 Stream 2048 random bits with concurrent pops -> popped bytes match a reference model in order across a pointer wrap; REQ-019 holds every cycle.
REQ-033 Assert rst=0 after 13 bits, asynchronous to clk -> all outputs cleared immediately; post-release stream restarts at byte 0.
